// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: cursor, card-pick and match bookkeeping for the 6x6 memory game.
// Optional feature: define CURSOR_WRAP_EN to make edge moves wrap instead of saturate.
module memory_game_ctrl #(
    parameter int unsigned SHOW_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btnUp,
    input  logic        btnDown,
    input  logic        btnLeft,
    input  logic        btnRight,
    input  logic        btnSelect,
    output logic [5:0]  faceAddr,
    input  logic [4:0]  faceData,
    output logic [5:0]  mem6x6,
    output logic [5:0]  card1,
    output logic [5:0]  card2,
    output logic [5:0]  selectedCard,
    output logic [35:0] matched,
    output logic [4:0]  pairsFound,
    output logic        gameOver
);

    localparam int unsigned CNT_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [5:0]  NONE  = 6'h3F;

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {PICK1, PICK2, SHOW, DONE} state_t;

    state_t             state, state_d;
    logic [5:0]         mem_d, card1_d, card2_d, sel_d;
    logic [35:0]        matched_d;
    logic [4:0]         pairs_d;
    logic               over_d;
    logic [4:0]         face1, face1_d;
    logic               is_match, is_match_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [2:0]         col;
    logic [5:0]         cur_moved;

    // Face ROM is addressed directly by the cursor.
    assign faceAddr = mem6x6;

    // Cursor after the highest-priority move button (select is handled by the FSM).
    always_comb begin
        col       = 3'(mem6x6 % 6'd6);
        cur_moved = mem6x6;
        if (btnUp) begin
            if (mem6x6 >= 6'd6)  cur_moved = mem6x6 - 6'd6;
            else if (WRAP_EN)    cur_moved = mem6x6 + 6'd30;
        end else if (btnDown) begin
            if (mem6x6 < 6'd30)  cur_moved = mem6x6 + 6'd6;
            else if (WRAP_EN)    cur_moved = mem6x6 - 6'd30;
        end else if (btnLeft) begin
            if (col != 3'd0)     cur_moved = mem6x6 - 6'd1;
            else if (WRAP_EN)    cur_moved = mem6x6 + 6'd5;
        end else if (btnRight) begin
            if (col != 3'd5)     cur_moved = mem6x6 + 6'd1;
            else if (WRAP_EN)    cur_moved = mem6x6 - 6'd5;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        mem_d      = mem6x6;
        card1_d    = card1;
        card2_d    = card2;
        sel_d      = selectedCard;
        matched_d  = matched;
        pairs_d    = pairsFound;
        over_d     = gameOver;
        face1_d    = face1;
        is_match_d = is_match;
        cnt_d      = cnt;
        case (state)
            PICK1: begin
                if (btnSelect) begin
                    if (!matched[mem6x6]) begin
                        card1_d = mem6x6;
                        sel_d   = mem6x6;
                        face1_d = faceData;
                        state_d = PICK2;
                    end
                end else begin
                    mem_d = cur_moved;
                end
            end
            PICK2: begin
                if (btnSelect) begin
                    if (!matched[mem6x6] && (mem6x6 != card1)) begin
                        card2_d    = mem6x6;
                        sel_d      = mem6x6;
                        is_match_d = (faceData == face1);
                        cnt_d      = CNT_W'(SHOW_CYCLES);
                        state_d    = SHOW;
                    end
                end else begin
                    mem_d = cur_moved;
                end
            end
            SHOW: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_d   = '0;
                    card1_d = NONE;
                    card2_d = NONE;
                    sel_d   = NONE;
                    if (is_match) begin
                        matched_d = matched | (36'(1) << card1) | (36'(1) << card2);
                        pairs_d   = pairsFound + 5'd1;
                    end
                    if (is_match && (pairsFound == 5'd17)) begin
                        state_d = DONE;
                        over_d  = 1'b1;
                    end else begin
                        state_d = PICK1;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                over_d = 1'b1;
            end
            default: state_d = PICK1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= PICK1;
            mem6x6       <= 6'd0;
            card1        <= NONE;
            card2        <= NONE;
            selectedCard <= NONE;
            matched      <= '0;
            pairsFound   <= 5'd0;
            gameOver     <= 1'b0;
            face1        <= 5'd0;
            is_match     <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_d;
            mem6x6       <= mem_d;
            card1        <= card1_d;
            card2        <= card2_d;
            selectedCard <= sel_d;
            matched      <= matched_d;
            pairsFound   <= pairs_d;
            gameOver     <= over_d;
            face1        <= face1_d;
            is_match     <= is_match_d;
            cnt          <= cnt_d;
        end
    end

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Game-control stage that drives the 6x6 LED grid driver. It turns debounced button pulses into a cursor position, records the first and second card picks, compares card faces through an external face ROM, and holds both picks visible for a fixed time. It then records a match or hides the mismatch. Its `mem6x6`, `card1`, `card2` and `selectedCard` outputs connect one-to-one to the grid driver inputs of the same names.

## Interface
- `SHOW_CYCLES`, default 25000000: cycles both picked cards stay displayed (0.5 s at 50 MHz); must be ≥1.
- `clock`  in  1  system clock; everything on rising edge.
- `reset`  in  1  synchronous, active-high.
- `btnUp`, `btnDown`, `btnLeft`, `btnRight`, `btnSelect`  in  1 each  single-cycle, already-debounced pulses.
- `faceAddr`  out  6  face ROM address; combinationally equal to `mem6x6`.
- `faceData`  in  5  face ROM data for `faceAddr`, valid in the same cycle (combinational ROM).
- `mem6x6`  out  6  cursor index 0..35 (row = idx/6, col = idx%6).
- `card1`, `card2`, `selectedCard`  out  6 each  picked card indices; 6'h3F = none.
- `matched`  out  36  bit i set once card i is part of a found pair.
- `pairsFound`  out  5  0..18.
- `gameOver`  out  1  high once all 18 pairs are found.

## Operation
- The state machine has four states: PICK1, PICK2, SHOW, DONE.
- Only one button action is taken per cycle. Priority is select > up > down > left > right; lower-priority pulses in the same cycle are dropped.
- **Cursor movement**
  - The cursor moves in PICK1 and PICK2 only. Moves in SHOW and DONE are ignored.
  - Up/down change the index by ∓6. Left/right change the index by ∓1 within the current row.
  - At a grid edge the cursor saturates (no change); see Configuration for the wrap option.
- **PICK1**
  - Select on a card whose `matched` bit is set is ignored.
  - Otherwise: `card1` ← `mem6x6`, `selectedCard` ← `mem6x6`, `face1` ← `faceData`; go to PICK2.
- **PICK2**
  - Select on a matched card, or on `card1`, is ignored.
  - Otherwise: `card2` ← `mem6x6`, `selectedCard` ← `mem6x6`, `isMatch` ← (`faceData` == `face1`); load the show counter; go to SHOW.
- **SHOW**
  - Count `SHOW_CYCLES` cycles. In the final cycle, if `isMatch`: set `matched[card1]` and `matched[card2]`, and increment `pairsFound`.
  - `card1`, `card2` and `selectedCard` ← 6'h3F.
  - Next state is DONE if `pairsFound` reaches 18, else PICK1.
- **DONE**
  - `gameOver` = 1. All inputs are ignored until `reset`.
- **Reset values** (also applied mid-game, including mid-SHOW):
  - `mem6x6` = 0; `card1` = `card2` = `selectedCard` = 6'h3F.
  - `matched` = 0, `pairsFound` = 0, `gameOver` = 0.
  - State = PICK1; show counter = 0.
- `face1`, `isMatch` and the show counter are internal registers.
- The show counter is `$clog2(SHOW_CYCLES+1)` bits wide.

## Timing
- Button to register update: 1 cycle. A pulse sampled at edge N is visible on the outputs after edge N.
- SHOW is entered at edge E (the second-select edge). Clearing of the pick registers and the `matched`/`pairsFound` update take effect at edge E+`SHOW_CYCLES`.
- `gameOver` rises on the same edge as the 18th `pairsFound` increment.
- `faceAddr` has zero latency from `mem6x6`. Faces are sampled on the select edge.
- All outputs are registered except `faceAddr`.

## Configuration
- `CURSOR_WRAP_EN` defined: edge moves wrap.
  - Up at row 0 goes to row 5, and down at row 5 goes to row 0, same column.
  - Left at col 0 goes to col 5, and right at col 5 goes to col 0, same row.
- `CURSOR_WRAP_EN` undefined: edge moves saturate; the cursor is unchanged.

## Test plan
Bench setup: `SHOW_CYCLES`=4; face ROM `faceData` = `faceAddr`>>1, so cards 2k and 2k+1 form a pair.

1. Assert `reset` for 2 cycles. Required: `mem6x6`=0, `card1`/`card2`/`selectedCard`=6'h3F, `matched`=0, `pairsFound`=0, `gameOver`=0.
2. Navigation, starting from 0:
   - 5× right → 5. One more right → 5 (saturate) or 0 (`CURSOR_WRAP_EN`).
   - From 5, down → 11. From 0, up → 0 (saturate) or 30 (wrap).
   - Same-cycle up+right from 0 → up only taken.
3. Match path: select at 0, right, select at 1.
   - After the second select: `card1`=0, `card2`=1, `selectedCard`=1.
   - 4 cycles later: `matched[1:0]`=2'b11, `pairsFound`=1, pick outputs = 6'h3F.
4. Mismatch path: select 2, then select 4. After 4 cycles: `matched` unchanged, `pairsFound` unchanged, pick outputs = 6'h3F.
5. Ignore rules, each leaving state and picks unchanged:
   - PICK1 select on matched card 0.
   - PICK2 re-select of `card1`.
   - Moves and selects during SHOW.
6. End and reset:
   - Find all 18 pairs → `gameOver`=1 with `pairsFound`=18; further buttons have no effect.
   - Separately, assert `reset` mid-SHOW → all reset values on the next edge.
